// File: rtl/csa_pkg.sv
// Shared constants for the carry-save partial-product accumulator.
package csa_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int OUT_W_DEF = 2 * WIDTH_DEF;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    // Control FSM encoding, 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/csa_pp_accumulator_if.sv
// Request/result bundle between the accumulator and its driver / CPA capture.
interface csa_pp_accumulator_if #(
    parameter int WIDTH = csa_pkg::WIDTH_DEF,
    parameter int OUT_W = 2 * WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] x_out;
    logic [OUT_W-1:0] y_out;

    modport master (output start, a, b, out_ready,
                    input  busy, out_valid, x_out, y_out);
    modport slave  (input  start, a, b, out_ready,
                    output busy, out_valid, x_out, y_out);
endinterface

// File: rtl/csa_pp_accumulator_csa_row.sv
// One OUT_W-bit row of 3:2 compressors; carry output is already shifted left
// by one with the top carry dropped, so it can be fed straight back as c.
module csa_row #(
    parameter int OUT_W = csa_pkg::OUT_W_DEF
) (
    input  logic [OUT_W-1:0] s,
    input  logic [OUT_W-1:0] c,
    input  logic [OUT_W-1:0] pp,
    output logic [OUT_W-1:0] s_n,
    output logic [OUT_W-1:0] c_n
);
    // Majority of the top bit would only feed the discarded carry-out.
    logic [OUT_W-2:0] maj;

    assign s_n = s ^ c ^ pp;
    assign maj = (s[OUT_W-2:0] & c[OUT_W-2:0])
               | (s[OUT_W-2:0] & pp[OUT_W-2:0])
               | (c[OUT_W-2:0] & pp[OUT_W-2:0]);
    assign c_n = {maj, 1'b0};
endmodule

// File: rtl/csa_pp_accumulator.sv
// Sequential carry-save multiplier front end: folds one shifted partial product
// per cycle into a redundant sum/carry pair that a downstream CPA resolves.
module csa_pp_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    csa_pp_accumulator_if.slave  bus
);
    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               load, accum;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [OUT_W-1:0]   s_q, c_q;
    logic [OUT_W-1:0]   pp, s_n, c_n;
    logic               out_valid_q;

    // Partial product for the multiplier bit selected by count.
    assign pp = b_q[count_q] ? ({{(OUT_W-WIDTH){1'b0}}, a_q} << count_q) : '0;

    csa_row #(.OUT_W(OUT_W)) u_row (
        .s   (s_q),
        .c   (c_q),
        .pp  (pp),
        .s_n (s_n),
        .c_n (c_n)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath strobes; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accum   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                load    = 1'b1;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                accum = 1'b1;
                if (count_q == LAST) state_d = ST_HOLD;
            end
            ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture and sum/carry accumulation; S/C keep their value in IDLE
    // and HOLD so the CPA inputs stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
        end else if (load) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            s_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
        end else if (accum) begin
            s_q     <= s_n;
            c_q     <= c_n;
            count_q <= count_q + 1'b1;
        end
    end

    // out_valid rises on the same edge that enters HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid_q <= 1'b0;
        else     out_valid_q <= (state_d == ST_HOLD);
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = s_q;
    assign bus.y_out     = c_q;
endmodule

// File: tb/tb_csa_pp_accumulator.sv
// Scoreboard bench: expected products are queued at acceptance and compared
// against the CPA sum of x_out/y_out when the result is consumed.
module tb_csa_pp_accumulator;
    import csa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_pp_accumulator_if #(.WIDTH(16), .OUT_W(32)) bus ();
    csa_pp_accumulator #(.WIDTH(16), .OUT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // 33-bit CPA result: bit 32 is the carry-out.
    function automatic logic [63:0] cpa_sum();
        logic [32:0] s;
        s = {1'b0, bus.x_out} + {1'b0, bus.y_out};
        return 64'(s);
    endfunction

    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb,
                          input int hold, input bit poke);
        int          n;
        int          busy_cnt;
        logic [31:0] x0, y0, exp;
        @(negedge clk);
        bus.a = aa; bus.b = bb; bus.start = 1'b1;
        exp_q.push_back(32'(aa) * 32'(bb));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        n = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_cnt++;
            if (poke && n == 5) begin
                bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd2;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("latency", 64'(n), 64'd16);
        x0 = bus.x_out; y0 = bus.y_out;
        if (poke) begin
            bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd2;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_x", 64'(bus.x_out), 64'(x0));
            chk("hold_y", 64'(bus.y_out), 64'(y0));
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(17 + hold));
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        chk("cpa_sum", cpa_sum(), 64'(exp));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        chk("idle_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_keep", cpa_sum(), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_x", 64'(bus.x_out), 64'd0);
        chk("rst_y", 64'(bus.y_out), 64'd0);
        rst = 1'b0;

        run_op(16'd0, 16'd0, 0, 1'b0);
        run_op(16'd1, 16'd1, 0, 1'b0);
        run_op(16'd12, 16'd71, 0, 1'b0);
        run_op(16'd62, 16'd12, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 0, 1'b0);
        run_op(16'd5, 16'd16, 10, 1'b0);
        run_op(16'd4, 16'd1, 3, 1'b1);
        for (int i = 0; i < 4; i++)
            run_op(16'($urandom), 16'($urandom), i, 1'b0);

        // Abort mid-ACCUM: outputs clear without any clock edge.
        @(negedge clk);
        bus.a = 16'd100; bus.b = 16'd200; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", 64'(bus.busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_x", 64'(bus.x_out), 64'd0);
        chk("abort_y", 64'(bus.y_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd3, 16'd7, 0, 1'b0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
